// File: rtl/aes128_encrypt_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : aes128_encrypt_pipe_if
//  Purpose  : Streaming data bundle of the AES-128 encryption pipeline.
//             There is no handshake: one plaintext and one key are
//             presented on every clock, and one ciphertext leaves on every
//             clock.
//  Signals  : plaintext [127:0]  block to encrypt          (master -> slave)
//             key       [127:0]  cipher key for that block (master -> slave)
//             cypher    [127:0]  registered ciphertext     (slave  -> master)
//  Modports : master - block producer / ciphertext consumer
//             slave  - the encryption core
//  Revision : 1.0  initial release
// ============================================================================
interface aes128_encrypt_pipe_if;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic [127:0] cypher;

    modport master (output plaintext, output key, input cypher);
    modport slave  (input plaintext, input key, output cypher);
endinterface
`default_nettype wire

// File: rtl/aes128_encrypt_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : aes128_encrypt_pipe
//  Purpose  : Fully pipelined AES-128 forward cipher. It accepts one block
//             and one key per clock and produces one ciphertext per clock.
//             The ciphertext for a block sampled at edge N appears after
//             edge N+10. Each stage carries its own round key, so the key
//             may change on every cycle.
//  Ports    : clk    - rising-edge clock
//             reset  - asynchronous, active-low; clears every stage to zero
//             bus    - slave modport: plaintext/key in, cypher out
//  Revision : 1.0  initial release
// ============================================================================
module aes128_encrypt_pipe (
    input  logic                  clk,
    input  logic                  reset,
    aes128_encrypt_pipe_if.slave  bus
);

    // FIPS-197 forward S-box
    localparam logic [7:0] C_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constants, indexed by round number
    localparam logic [7:0] C_RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // ------------------------------------------------------------------------
    // Round primitives. Byte i of a 128-bit state sits at bits [127-8i -: 8],
    // in row i%4 and column i/4.
    // ------------------------------------------------------------------------
    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return C_SBOX[b];
    endfunction

    // Multiply by x in GF(2^8), reduction polynomial 0x11b
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sub_byte(w[31:24]), sub_byte(w[23:16]),
                sub_byte(w[15:8]),  sub_byte(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = sub_byte(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // Row r rotates left by r columns: out(r,c) = in(r,(c+r)%4)
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // One step of the AES-128 key expansion: previous round key -> next
    function automatic logic [127:0] next_round_key(input logic [127:0] rk,
                                                    input logic [7:0]   rcon);
        logic [31:0] w0, w1, w2, w3, t;
        t  = sub_word({rk[23:0], rk[31:24]}) ^ {rcon, 24'h0};
        w0 = rk[127:96] ^ t;
        w1 = rk[95:64]  ^ w0;
        w2 = rk[63:32]  ^ w1;
        w3 = rk[31:0]   ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // ------------------------------------------------------------------------
    // Pipeline storage. Stage 10 holds only data: its round key is consumed
    // in the same cycle it is derived and has no successor.
    // ------------------------------------------------------------------------
    logic [127:0] state_q [0:10];
    logic [127:0] key_q   [0:9];
    logic [127:0] state_d [1:10];
    logic [127:0] rk_d    [1:10];

    for (genvar r = 1; r <= 10; r++) begin : g_round
        assign rk_d[r] = next_round_key(key_q[r-1], C_RCON[r]);
        if (r < 10) begin : g_full
            assign state_d[r] = mix_columns(shift_rows(sub_bytes(state_q[r-1]))) ^ rk_d[r];
        end else begin : g_final
            assign state_d[r] = shift_rows(sub_bytes(state_q[r-1])) ^ rk_d[r];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= 10; i++) state_q[i] <= '0;
            for (int i = 0; i <= 9;  i++) key_q[i]   <= '0;
        end else begin
            // Initial AddRoundKey; the raw key becomes round key 0
            state_q[0] <= bus.plaintext ^ bus.key;
            key_q[0]   <= bus.key;
            for (int i = 1; i <= 10; i++) state_q[i] <= state_d[i];
            for (int i = 1; i <= 9;  i++) key_q[i]   <= rk_d[i];
        end
    end

    assign bus.cypher = state_q[10];

endmodule
`default_nettype wire

// File: tb/tb_aes128_encrypt_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_aes128_encrypt_pipe
//  Purpose  : Directed self-checking bench for aes128_encrypt_pipe:
//             FIPS-197 / SP800-38A vectors, streaming, per-cycle key change,
//             and asynchronous reset mid-stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes128_encrypt_pipe;

    logic clk;
    logic reset;

    aes128_encrypt_pipe_if bus ();

    aes128_encrypt_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] C_K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C_P1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C_C1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_K2  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_P2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] C_PSP = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C_CSP = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    int n_vec = 0;
    int n_err = 0;
    int ncyc  = 0;

    logic [7:0]   tb_sbox  [256];
    logic [127:0] hist_pt  [256];
    logic [127:0] hist_key [256];

    // ---------------- reference model (S-box built from GF inverse) -------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            b = inv;
            tb_sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                           ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [4][4];
        logic [7:0]   u [4][4];
        logic [7:0]   a [4];
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]], tb_sbox[t[31:24]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    u[r][c] = tb_sbox[s[r][(c+r)%4]];
            s = u;
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[r][c];
                    for (int r = 0; r < 4; r++)
                        s[r][c] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03)
                                  ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = s[r][c] ^ w[4*rnd+c][31-8*r -: 8];
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[r][c];
        return o;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ne(input string tag, input logic [127:0] obs, input logic [127:0] bad);
        n_vec++;
        assert (obs !== bad) else begin
            n_err++;
            $error("FAIL %s: observed %h must not equal %h", tag, obs, bad);
        end
    endtask

    // Called at a falling edge: drive inputs, let one rising edge capture
    // them, return at the next falling edge.
    task automatic step(input logic [127:0] p, input logic [127:0] k);
        bus.plaintext = p;
        bus.key       = k;
        if (ncyc < 256) begin
            hist_pt[ncyc]  = p;
            hist_key[ncyc] = k;
        end
        @(posedge clk);
        @(negedge clk);
        ncyc++;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset         = 1'b0;
        bus.plaintext = '0;
        bus.key       = '0;
        build_sbox();

        // Reset state
        #1;
        check_eq("reset_state", bus.cypher, 128'h0);
        @(negedge clk);
        @(negedge clk);
        check_eq("reset_held", bus.cypher, 128'h0);
        reset = 1'b1;
        ncyc  = 0;

        // FIPS-197 B: result after exactly 11 edges, not earlier
        step(C_P1, C_K1);
        repeat (9) step('0, '0);
        check_ne("fips_b_not_early", bus.cypher, C_C1);
        step('0, '0);
        check_eq("fips_b", bus.cypher, C_C1);

        // C.1, all-zero, SP800-38A back to back
        step(C_P2, C_K2);
        step('0, '0);
        step(C_PSP, C_K1);
        repeat (8) step('0, '0);
        check_eq("fips_c1", bus.cypher, C_C2);
        step('0, '0);
        check_eq("all_zero", bus.cypher, C_CZ);
        step('0, '0);
        check_eq("sp800_38a", bus.cypher, C_CSP);

        // Streaming counter blocks 0..15 under one key, no gaps
        for (int i = 0; i < 26; i++) begin
            step((i < 16) ? 128'(i) : '0, C_K1);
            if (i >= 10)
                check_eq("stream", bus.cypher,
                         model_enc(hist_pt[ncyc-11], hist_key[ncyc-11]));
        end

        // Key changes every cycle: alternate vector sets 1 and 2
        for (int i = 0; i < 22; i++) begin
            if (i % 2 == 0) step(C_P1, C_K1);
            else            step(C_P2, C_K2);
            if (i >= 10)
                check_eq("alternate", bus.cypher, (i % 2 == 0) ? C_C1 : C_C2);
        end

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) step(C_P1, C_K1);
            else            step(C_P2, C_K2);
        end
        reset = 1'b0;
        #1;
        check_eq("async_reset", bus.cypher, 128'h0);
        bus.plaintext = C_P2;
        bus.key       = C_K2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("reset_hold", bus.cypher, 128'h0);
        end
        reset = 1'b1;
        step(C_P1, C_K1);
        for (int i = 0; i < 9; i++) begin
            step('0, '0);
            check_ne("no_stale_c1", bus.cypher, C_C1);
            check_ne("no_stale_c2", bus.cypher, C_C2);
        end
        step('0, '0);
        check_eq("post_reset_fips_b", bus.cypher, C_C1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
